// File: rtl/nvram_upload_reader_pkg.sv
// nvram_upload_reader_pkg: state encoding and default NVRAM ioctl index, shared by the upload reader and the download-side writer
package nvram_upload_reader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [7:0] NVRAM_INDEX = 8'hFF;
endpackage

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: streams a RAM image to data_io's ioctl_din during host uploads
module nvram_upload_reader
  import nvram_upload_reader_pkg::*;
#(
  parameter int AW = 10,
  parameter int SIZE = 1024,
  parameter logic [7:0] INDEX = NVRAM_INDEX
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          ram_valid,
  output logic          busy,
  output logic          late
);
  localparam logic [AW:0] LIM = (AW+1)'(SIZE);
  state_t state, state_d;
  logic [AW:0] cnt, cnt_inc;
  logic active, active_q, wr_q, start, stb, in_range, done, go;
  logic pend, drain, drain_d, restart, restart_d;
  assign active = ioctl_upload & (ioctl_index == INDEX);
  assign start = active & ~active_q;
  assign stb = active & ioctl_wr & ~wr_q;
  assign in_range = cnt < LIM;
  assign cnt_inc = in_range ? cnt + 1'b1 : cnt;
  assign done = (state == FETCH) & (~in_range | ram_valid);
  // a restart requested while an abandoned read drains begins on that read's ram_valid
  assign go = (state == IDLE) & active & (start | restart) & (~drain | ram_valid);
  assign ram_addr = cnt[AW-1:0];
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = !active ? IDLE :
              (state == IDLE) ? (go ? FETCH : IDLE) :
              (state == FETCH) ? ((done & ~(pend | stb)) ? HOLD : FETCH) :
              (stb ? FETCH : HOLD);
    drain_d = drain ? ~ram_valid : (state == FETCH) & in_range & ~active & ~ram_valid;
    restart_d = (state == IDLE) & active & (start | restart) & drain & ~ram_valid;
  end
  always_comb begin
    ram_rd = ((state == FETCH) & in_range) | drain;
    busy = (state == FETCH) | drain;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      active_q <= 1'b0;
      wr_q <= 1'b0;
      cnt <= '0;
      pend <= 1'b0;
      late <= 1'b0;
      drain <= 1'b0;
      restart <= 1'b0;
      ioctl_din <= 8'hFF;
    end else begin
      active_q <= active;
      wr_q <= ioctl_wr;
      drain <= drain_d;
      restart <= restart_d;
      if (go) begin
        cnt <= '0;
        pend <= 1'b0;
        late <= 1'b0;
      end else if (!active) pend <= 1'b0;
      else if (state == FETCH) begin
        late <= late | stb;
        if (done) begin
          ioctl_din <= in_range ? ram_q : 8'hFF;
          pend <= 1'b0;
          if (pend | stb) cnt <= cnt_inc;
        end else pend <= pend | stb;
      end else if (state == HOLD && stb) cnt <= cnt_inc;
    end
endmodule

// File: tb/tb_nvram_upload_reader.sv
// tb_nvram_upload_reader: directed/randomised upload scenarios against a latency-programmable RAM model
module tb_nvram_upload_reader;
  localparam int AW = 5;
  localparam int SIZE = 16;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic ram_valid = 1'b0, spur = 1'b0;
  logic [7:0] ioctl_index = 8'hFF, ram_q = 8'h00, ioctl_din;
  logic [AW-1:0] ram_addr, run_addr = '0;
  logic ram_rd, busy, late;
  logic [7:0] mem [32];
  int lat = 0, wcnt = 0, run = 0, rd_cycles = 0, oob = 0, unstable = 0;
  int holds[$];
  int fetched[$];
  int checks = 0, errors = 0;

  nvram_upload_reader #(.AW(AW), .SIZE(SIZE), .INDEX(8'hFF)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_din(ioctl_din),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .ram_valid(ram_valid),
    .busy(busy), .late(late)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM answers lat+1 edges after it first sees ram_rd; spur injects an unsolicited valid
  always @(posedge clk_sys) begin
    ram_valid <= spur;
    if (spur) ram_q <= 8'h00;
    if (ram_rd && !ram_valid) begin
      if (wcnt == lat) begin
        ram_valid <= 1'b1;
        ram_q <= mem[ram_addr];
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else wcnt <= 0;
  end

  always @(posedge clk_sys) begin
    if (reset) run <= 0;
    else if (ram_rd) begin
      rd_cycles <= rd_cycles + 1;
      if (ram_addr >= 5'(SIZE)) oob <= oob + 1;
      if (run != 0 && ram_addr != run_addr) unstable <= unstable + 1;
      run_addr <= ram_addr;
      if (ram_valid) begin
        holds.push_back(run + 1);
        fetched.push_back(int'(ram_addr));
        run <= 0;
      end else run <= run + 1;
    end else run <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expb(input int k);
    return k < SIZE ? mem[k] : 8'hFF;
  endfunction

  task automatic pulse();
    ioctl_wr = 1'b1;
    @(negedge clk_sys) ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    for (int i = 0; i < max && busy; i++) @(negedge clk_sys);
    check(tag, busy, 0);
  endtask

  task automatic restart(input string tag);
    @(negedge clk_sys) ioctl_upload = 1'b0;
    @(negedge clk_sys) ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check({tag, "_rd"}, ram_rd, 1);
    check({tag, "_addr"}, ram_addr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, fi, rc, mn, mx;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_din", ioctl_din, 8'hFF);
    check("rst_addr", ram_addr, 0);
    check("rst_rd", ram_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_late", late, 0);
    // zero-latency RAM, full image plus two bytes past the end
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("start_rd", ram_rd, 1);
    check("start_addr", ram_addr, 0);
    repeat (2) @(negedge clk_sys);
    for (int k = 0; k <= SIZE + 1; k++) begin
      check("z_busy", busy, 0);
      check("z_din", ioctl_din, expb(k));
      check("z_late", late, 0);
      if (k <= SIZE) begin
        pulse();
        check("z_rd", ram_rd, 32'(k + 1 < SIZE));
        check("z_busy_fetch", busy, 1);
        if (k + 1 < SIZE) check("z_addr", ram_addr, k + 1);
        @(negedge clk_sys);
        if (k + 1 >= SIZE) check("z_oob_din", ioctl_din, 8'hFF);
        @(negedge clk_sys);
        check("z_din3", ioctl_din, expb(k + 1));
        repeat (2) @(negedge clk_sys);
      end
    end
    spur = 1'b1;
    @(negedge clk_sys) spur = 1'b0;
    @(negedge clk_sys);
    check("spur_hold_din", ioctl_din, 8'hFF);
    check("spur_hold_busy", busy, 0);
    // slow RAM, relaxed strobes, random image
    lat = 5;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    hi = holds.size();
    restart("l_start");
    wait_idle(40, "l_first");
    check("l_din0", ioctl_din, mem[0]);
    for (int k = 0; k < 7; k++) begin
      pulse();
      repeat (19) @(negedge clk_sys);
      check("l_busy", busy, 0);
      check("l_din", ioctl_din, expb(k + 1));
      check("l_late", late, 0);
    end
    mn = 999;
    mx = 0;
    for (int i = hi; i < holds.size(); i++) begin
      mn = holds[i] < mn ? holds[i] : mn;
      mx = holds[i] > mx ? holds[i] : mx;
    end
    check("l_hold_min", mn, 7);
    check("l_hold_max", mx, 7);
    // strobes faster than the RAM: one pending strobe is kept, the rest only flag late
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    restart("f_start");
    wait_idle(40, "f_first");
    check("f_din0", ioctl_din, 8'h11);
    fi = fetched.size();
    for (int k = 0; k < 4; k++) begin
      pulse();
      @(negedge clk_sys);
    end
    wait_idle(60, "f_idle");
    check("f_late", late, 1);
    check("f_nfetch", fetched.size() - fi, 2);
    check("f_addr_a", fetched[fi], 1);
    check("f_addr_b", fetched[fi + 1], 2);
    check("f_din", ioctl_din, 8'h33);
    repeat (5) @(negedge clk_sys);
    check("f_late_sticky", late, 1);
    restart("f_restart");
    check("f_late_clear", late, 0);
    // drop the upload mid-fetch and re-request it while the read drains
    wait_idle(40, "d_first");
    check("d_din0", ioctl_din, 8'h11);
    pulse();
    wait_idle(40, "d_second");
    check("d_din1", ioctl_din, 8'h22);
    pulse();
    check("d_rd", ram_rd, 1);
    check("d_addr", ram_addr, 2);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("d_drain_rd", ram_rd, 1);
    check("d_drain_busy", busy, 1);
    check("d_drain_addr", ram_addr, 2);
    ioctl_upload = 1'b1;
    for (int i = 0; i < 20 && ram_addr != 0; i++) @(negedge clk_sys);
    check("d_re_addr", ram_addr, 0);
    check("d_re_rd", ram_rd, 1);
    check("d_discard", ioctl_din, 8'h22);
    wait_idle(40, "d_re_idle");
    check("d_re_din", ioctl_din, 8'h11);
    // asynchronous reset in the middle of a fetch
    pulse();
    check("r_pre_rd", ram_rd, 1);
    #2 reset = 1'b1;
    ioctl_index = 8'h00;
    #1;
    check("r_din", ioctl_din, 8'hFF);
    check("r_addr", ram_addr, 0);
    check("r_rd", ram_rd, 0);
    check("r_busy", busy, 0);
    check("r_late", late, 0);
    @(negedge clk_sys) reset = 1'b0;
    // upload aimed at a different index must leave the block silent
    rc = rd_cycles;
    repeat (2) @(negedge clk_sys);
    for (int k = 0; k < 3; k++) begin
      pulse();
      repeat (3) @(negedge clk_sys);
    end
    spur = 1'b1;
    @(negedge clk_sys) spur = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("x_rd_cycles", rd_cycles - rc, 0);
    check("x_din", ioctl_din, 8'hFF);
    check("x_busy", busy, 0);
    check("x_late", late, 0);
    check("oob_reads", oob, 0);
    check("addr_unstable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
